// File: rtl/seg_debug_scanner.sv
// seg_debug_scanner: debug display engine.
// Selects one of CH packed channels and latches it once per scan frame.
// Shows the latched value on DIGITS multiplexed active-low seven-segment
// digits, with optional leading-zero blanking and a decimal-point marker.
// Also produces a peek address, either manual or auto-scanned.
module seg_debug_scanner #(
    parameter int DIGITS   = 8,
    parameter int CH       = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DWELL    = 50000000,
    parameter int ADDR_W   = 7,
    localparam int DW      = 4 * DIGITS,
    localparam int SW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH*DW-1:0]  ch_data,
    input  logic [SW-1:0]     ch_sel,
    input  logic              hold,
    input  logic              blank_lz,
    input  logic              auto_en,
    input  logic [ADDR_W-1:0] man_addr,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DWELL);

    logic [PW-1:0] pcnt;
    logic [IW-1:0] idx;
    logic [DW-1:0] frame;
    logic [CW-1:0] dcnt;
    logic          auto_en_p1;

    logic          tick;
    logic          boundary;
    logic [DW-1:0] sel_data;
    logic [3:0]    nib;
    logic          blank;
    logic          dp_hit;

    // Hex nibble to active-low segment pattern (bit6 = g .. bit0 = a).
    function automatic logic [6:0] seg_font(input logic [3:0] n);
        case (n)
            4'h0:    seg_font = 7'b1000000;
            4'h1:    seg_font = 7'b1111001;
            4'h2:    seg_font = 7'b0100100;
            4'h3:    seg_font = 7'b0110000;
            4'h4:    seg_font = 7'b0011001;
            4'h5:    seg_font = 7'b0010010;
            4'h6:    seg_font = 7'b0000010;
            4'h7:    seg_font = 7'b1111000;
            4'h8:    seg_font = 7'b0000000;
            4'h9:    seg_font = 7'b0011000;
            4'hA:    seg_font = 7'b0001000;
            4'hB:    seg_font = 7'b0000011;
            4'hC:    seg_font = 7'b1000110;
            4'hD:    seg_font = 7'b0100001;
            4'hE:    seg_font = 7'b0000110;
            default: seg_font = 7'b0001110;
        endcase
    endfunction

    // Slot timing, channel mux (out-of-range select reads as zero) and slot decode.
    always_comb begin
        tick     = (pcnt == PW'(SCAN_DIV - 1));
        boundary = tick && (idx == IW'(DIGITS - 1));
        sel_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (ch_sel == SW'(k)) sel_data = ch_data[k*DW +: DW];
        end
        nib    = frame[{idx, 2'b00} +: 4];
        blank  = blank_lz && (idx != '0) && ((frame >> {idx, 2'b00}) == '0);
        dp_hit = (int'(ch_sel) == int'(idx));
    end

    // Prescaler, digit index and frame latch; frame only moves at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            idx   <= '0;
            frame <= '0;
        end else begin
            if (tick) begin
                pcnt <= '0;
                idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                pcnt <= pcnt + PW'(1);
            end
            if (boundary && !hold) frame <= sel_data;
        end
    end

    // Registered digit drive, recomputed every cycle from the current slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= blank ? '1 : ~(DIGITS'(1) << idx);
            seg <= blank ? 7'h7F : seg_font(nib);
            dp  <= !(!blank && dp_hit);
        end
    end

    // Peek address: manual follow, or auto-scan restarting at 0 with a full dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt       <= '0;
            addr_out   <= '0;
            auto_en_p1 <= 1'b1;
        end else begin
            auto_en_p1 <= auto_en;
            if (!auto_en) begin
                dcnt     <= '0;
                addr_out <= man_addr;
            end else if (!auto_en_p1) begin
                dcnt     <= '0;
                addr_out <= '0;
            end else if (dcnt == CW'(DWELL - 1)) begin
                dcnt     <= '0;
                addr_out <= addr_out + ADDR_W'(1);
            end else begin
                dcnt <= dcnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_debug_scanner.sv
// Testbench for seg_debug_scanner with DIGITS=8, SCAN_DIV=4, DWELL=5, ADDR_W=3.
// A second instance with CH=6 covers the out-of-range channel select.
module tb_seg_debug_scanner;

    logic         clk;
    logic         rst_n;
    logic [255:0] ch_data;
    logic [191:0] ch_data2;
    logic [2:0]   ch_sel;
    logic [2:0]   ch_sel2;
    logic         hold;
    logic         blank_lz;
    logic         auto_en;
    logic [2:0]   man_addr;
    logic [2:0]   addr_out, addr_out2;
    logic [7:0]   an, an2;
    logic [6:0]   seg, seg2;
    logic         dp, dp2;

    int total;
    int bad;
    int cur;

    seg_debug_scanner #(.DIGITS(8), .CH(8), .SCAN_DIV(4), .DWELL(5), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_sel(ch_sel), .hold(hold),
        .blank_lz(blank_lz), .auto_en(auto_en), .man_addr(man_addr),
        .addr_out(addr_out), .an(an), .seg(seg), .dp(dp)
    );

    seg_debug_scanner #(.DIGITS(8), .CH(6), .SCAN_DIV(4), .DWELL(5), .ADDR_W(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data2), .ch_sel(ch_sel2), .hold(hold),
        .blank_lz(blank_lz), .auto_en(auto_en), .man_addr(man_addr),
        .addr_out(addr_out2), .an(an2), .seg(seg2), .dp(dp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one clock edge, then settle 1 time unit; cur = index of the last edge since release
    task automatic step();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic step_to(input int k);
        while (cur < k) step();
    endtask

    // reset, released just after an edge so the next edge is edge 0
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur = -1;
    endtask

    task automatic test_reset();
        ch_data = '0; ch_sel = 3'd3; hold = 0; blank_lz = 0; auto_en = 0; man_addr = 3'd6;
        do_reset();
        step_to(9);
        total++;
        if (addr_out !== 3'd6) begin bad++; $display("FAIL rst_pre_addr got=%h exp=%h", addr_out, 3'd6); end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (an !== 8'hFF) begin bad++; $display("FAIL rst_an got=%h exp=%h", an, 8'hFF); end
        total++;
        if (seg !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%h exp=%h", seg, 7'h7F); end
        total++;
        if (dp !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b exp=1", dp); end
        total++;
        if (addr_out !== 3'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", addr_out); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur = -1;
        step_to(0);
        total++;
        if (an !== 8'hFE) begin bad++; $display("FAIL rel_an got=%h exp=%h", an, 8'hFE); end
        total++;
        if (seg !== 7'h40) begin bad++; $display("FAIL rel_seg got=%h exp=%h", seg, 7'h40); end
        total++;
        if (dp !== 1'b1) begin bad++; $display("FAIL rel_dp got=%b exp=1", dp); end
    endtask

    task automatic test_scan_latch();
        logic [6:0] exp_seg [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        logic [7:0] exp_an;
        int s;
        ch_data = '0; ch_data[3*32 +: 32] = 32'h1234ABCD;
        ch_sel = 3'd3; hold = 0; blank_lz = 0; auto_en = 1; man_addr = 3'd0;
        do_reset();
        // zero frame still shown before the first boundary
        step_to(5);
        total++;
        if (an !== 8'hFD || seg !== 7'h40) begin
            bad++; $display("FAIL scan_pre an=%h seg=%h exp an=FD seg=40", an, seg);
        end
        for (int k = 32; k < 64; k++) begin
            step_to(k);
            s = (k - 32) / 4;
            exp_an = ~(8'h01 << s);
            total++;
            if (an !== exp_an) begin bad++; $display("FAIL scan_an edge=%0d got=%h exp=%h", k, an, exp_an); end
            total++;
            if (seg !== exp_seg[s]) begin bad++; $display("FAIL scan_seg edge=%0d got=%h exp=%h", k, seg, exp_seg[s]); end
            total++;
            if (dp !== (s != 3)) begin bad++; $display("FAIL scan_dp edge=%0d got=%b exp=%b", k, dp, (s != 3)); end
        end
    endtask

    task automatic test_blanking();
        ch_data = '0; ch_data[3*32 +: 32] = 32'h000000A0;
        ch_sel = 3'd3; hold = 0; blank_lz = 1; auto_en = 1;
        do_reset();
        // zero frame: only slot 0 lit
        for (int k = 0; k < 32; k++) begin
            step_to(k);
            total++;
            if ((k / 4) == 0) begin
                if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
                    bad++; $display("FAIL blank0_lit edge=%0d an=%h seg=%h dp=%b exp FE/40/1", k, an, seg, dp);
                end
            end else begin
                if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
                    bad++; $display("FAIL blank0_off edge=%0d an=%h seg=%h dp=%b exp FF/7F/1", k, an, seg, dp);
                end
            end
        end
        for (int k = 32; k < 64; k++) begin
            step_to(k);
            total++;
            case ((k - 32) / 4)
                0: if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
                       bad++; $display("FAIL blankA_s0 edge=%0d an=%h seg=%h dp=%b exp FE/40/1", k, an, seg, dp);
                   end
                1: if (an !== 8'hFD || seg !== 7'h08 || dp !== 1'b1) begin
                       bad++; $display("FAIL blankA_s1 edge=%0d an=%h seg=%h dp=%b exp FD/08/1", k, an, seg, dp);
                   end
                default: if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
                       bad++; $display("FAIL blankA_off edge=%0d an=%h seg=%h dp=%b exp FF/7F/1", k, an, seg, dp);
                   end
            endcase
        end
    endtask

    task automatic test_hold_tearing();
        ch_data = '0; ch_data[3*32 +: 32] = 32'h1234ABCD;
        ch_sel = 3'd3; hold = 0; blank_lz = 0; auto_en = 1;
        do_reset();
        step_to(40);
        ch_data[3*32 +: 32] = 32'hFEDCBA98;
        step_to(44);
        total++;
        if (an !== 8'hF7 || seg !== 7'h08 || dp !== 1'b0) begin
            bad++; $display("FAIL tear_old_s3 an=%h seg=%h dp=%b exp F7/08/0", an, seg, dp);
        end
        step_to(60);
        total++;
        if (an !== 8'h7F || seg !== 7'h79) begin bad++; $display("FAIL tear_old_s7 an=%h seg=%h exp 7F/79", an, seg); end
        step_to(64);
        total++;
        if (an !== 8'hFE || seg !== 7'h00) begin bad++; $display("FAIL tear_new_s0 an=%h seg=%h exp FE/00", an, seg); end
        step_to(68);
        total++;
        if (an !== 8'hFD || seg !== 7'h18) begin bad++; $display("FAIL tear_new_s1 an=%h seg=%h exp FD/18", an, seg); end
        hold = 1;
        ch_data[3*32 +: 32] = 32'h00000005;
        step_to(96);
        total++;
        if (seg !== 7'h00) begin bad++; $display("FAIL hold_b1 got=%h exp=00", seg); end
        step_to(128);
        total++;
        if (seg !== 7'h00) begin bad++; $display("FAIL hold_b2 got=%h exp=00", seg); end
        step_to(160);
        total++;
        if (an !== 8'hFE || seg !== 7'h00) begin bad++; $display("FAIL hold_b3 an=%h seg=%h exp FE/00", an, seg); end
        step_to(164);
        total++;
        if (seg !== 7'h18) begin bad++; $display("FAIL hold_b3_s1 got=%h exp=18", seg); end
        hold = 0;
        step_to(192);
        total++;
        if (an !== 8'hFE || seg !== 7'h12) begin bad++; $display("FAIL unhold_s0 an=%h seg=%h exp FE/12", an, seg); end
        step_to(196);
        total++;
        if (seg !== 7'h40) begin bad++; $display("FAIL unhold_s1 got=%h exp=40", seg); end
    endtask

    task automatic test_auto_scan();
        logic [2:0] exp_a;
        ch_data = '0; ch_sel = 3'd0; hold = 0; blank_lz = 0; auto_en = 1; man_addr = 3'd0;
        do_reset();
        total++;
        if (addr_out !== 3'd0) begin bad++; $display("FAIL auto_start got=%h exp=0", addr_out); end
        for (int k = 0; k <= 46; k++) begin
            step_to(k);
            exp_a = 3'(((k + 1) / 5) % 8);
            total++;
            if (addr_out !== exp_a) begin bad++; $display("FAIL auto_addr edge=%0d got=%h exp=%h", k, addr_out, exp_a); end
        end
        auto_en = 0;
        man_addr = 3'd5;
        step_to(47);
        total++;
        if (addr_out !== 3'd5) begin bad++; $display("FAIL man_addr got=%h exp=5", addr_out); end
        step_to(50);
        total++;
        if (addr_out !== 3'd5) begin bad++; $display("FAIL man_hold got=%h exp=5", addr_out); end
        auto_en = 1;
        for (int k = 51; k <= 56; k++) begin
            step_to(k);
            exp_a = (k == 56) ? 3'd1 : 3'd0;
            total++;
            if (addr_out !== exp_a) begin bad++; $display("FAIL auto_restart edge=%0d got=%h exp=%h", k, addr_out, exp_a); end
        end
    endtask

    task automatic test_out_of_range();
        ch_data2 = {6{32'h87654321}};
        ch_sel2 = 3'd2; hold = 0; blank_lz = 1; auto_en = 1;
        do_reset();
        step_to(32);
        total++;
        if (an2 !== 8'hFE || seg2 !== 7'h79) begin bad++; $display("FAIL oor_valid an=%h seg=%h exp FE/79", an2, seg2); end
        ch_sel2 = 3'd7;
        for (int k = 64; k < 96; k++) begin
            step_to(k);
            total++;
            if ((k - 64) / 4 == 0) begin
                if (an2 !== 8'hFE || seg2 !== 7'h40 || dp2 !== 1'b1) begin
                    bad++; $display("FAIL oor_s0 edge=%0d an=%h seg=%h dp=%b exp FE/40/1", k, an2, seg2, dp2);
                end
            end else begin
                if (an2 !== 8'hFF || seg2 !== 7'h7F || dp2 !== 1'b1) begin
                    bad++; $display("FAIL oor_off edge=%0d an=%h seg=%h dp=%b exp FF/7F/1", k, an2, seg2, dp2);
                end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; cur = -1;
        rst_n = 1'b0;
        ch_data = '0; ch_data2 = '0; ch_sel = '0; ch_sel2 = '0;
        hold = 0; blank_lz = 0; auto_en = 0; man_addr = '0;
        test_reset();
        test_scan_latch();
        test_blanking();
        test_hold_tearing();
        test_auto_scan();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
